// File: rtl/alu_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, with valid/ready request and result handshakes and flush.
module alu_muldiv #(
   parameter int XLEN = 32,
   localparam int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] rd_data
);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q;
   logic                neg_q;
   logic [XLEN-1:0]     b_q;
   logic [2*XLEN-1:0]   acc_q;
   logic [CNT_W-1:0]    cnt_q;

   logic signed [XLEN-1:0] rs1_s, rs2_s;
   logic                accept, last_step;
   logic                a_signed, b_signed, neg1, neg2, res_neg;
   logic                div_zero, div_ovf, special;
   logic [XLEN-1:0]     abs1, abs2, special_res, fix_res;
   logic [XLEN:0]       mul_sum, div_trial;
   logic [2*XLEN-1:0]   mul_next, div_next, prod;

   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   assign rs1_s     = rs1_data;
   assign rs2_s     = rs2_data;
   assign in_ready  = (state_q == IDLE) && !flush && !reset;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign last_step = (cnt_q == CNT_W'(XLEN - 1));

   // Operand conditioning at accept: magnitudes plus the sign of the final result
   always_comb begin
      a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
      b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      neg1     = a_signed && (rs1_s < 0);
      neg2     = b_signed && (rs2_s < 0);
      abs1     = cond_neg(rs1_data, neg1);
      abs2     = cond_neg(rs2_data, neg2);
      case (op)
         OP_MULH, OP_DIV: res_neg = neg1 ^ neg2;
         OP_MULHSU, OP_REM: res_neg = neg1;
         default: res_neg = 1'b0;
      endcase
      div_zero = op[2] && (rs2_data == '0);
      div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                 (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
      special  = div_zero || div_ovf;
      if (div_zero) special_res = op[1] ? rs1_data : '1;
      else          special_res = op[1] ? '0 : rs1_data;
   end

   // One radix-2 step; the divide trial needs XLEN+1 bits since 2*rem+1 can exceed XLEN
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
      mul_next  = {mul_sum, acc_q[XLEN-1:1]};
      div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, b_q};
      div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                  : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
   end

   always_comb begin
      prod = cond_neg2(acc_q, neg_q);
      if (!op_q[2])     fix_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      else if (!op_q[1]) fix_res = cond_neg(acc_q[XLEN-1:0], neg_q);
      else               fix_res = cond_neg(acc_q[2*XLEN-1:XLEN], neg_q);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = special ? DONE : CALC;
         CALC: if (last_step) state_d = FIX;
         FIX:  state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         rd_data <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  cnt_q <= '0;
                  if (special) rd_data <= special_res;
               end
            end
            CALC: cnt_q <= cnt_q + 1'b1;
            FIX:  if (!flush) rd_data <= fix_res;
            default: ;
         endcase
      end
   end

   // Datapath registers carry no reset; they are always loaded at accept before use
   always_ff @(posedge clk) begin
      if (state_q == IDLE && accept) begin
         op_q  <= op;
         neg_q <= res_neg;
         b_q   <= op[2] ? abs2 : abs1;
         acc_q <= op[2] ? {{XLEN{1'b0}}, abs1} : {{XLEN{1'b0}}, abs2};
      end else if (state_q == CALC) begin
         acc_q <= op_q[2] ? div_next : mul_next;
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv (XLEN=32): stimulus pushes reference results,
// a negedge monitor checks latency and data on every output handshake.
module tb_alu_muldiv;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [2:0]  op;
   logic [31:0] rs1_data, rs2_data, rd_data;

   typedef struct packed {
      logic [31:0] d;
      logic [7:0]  lat;
      logic [2:0]  op;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0, errors = 0, hs_cnt = 0, cyc = 0, acc_cyc = 0;
   logic prev_ov = 1'b0;

   alu_muldiv #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
      .in_ready(in_ready), .op(op), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .out_valid(out_valid), .out_ready(out_ready), .rd_data(rd_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference: RISC-V M semantics from plain 64-bit / int arithmetic
   function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      logic [63:0]        up;
      int                 sa, sb;
      sa = a;
      sb = b;
      up = {32'b0, a} * {32'b0, b};
      case (o)
         3'd0: return up[31:0];
         3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
         3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return sp[63:32]; end
         3'd3: return up[63:32];
         3'd4: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            return sa / sb;
         end
         3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            return sa % sb;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [7:0] ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      if (o[2] && b == 0) return 8'd0;
      if ((o == 3'd4 || o == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 8'd0;
      return 8'd33;
   endfunction

   // Monitor: latency on the rising out_valid, data on each handshake
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (in_valid && in_ready) acc_cyc = cyc + 1;
            if (out_valid && !prev_ov) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_valid: rd_data %h with no request outstanding", rd_data);
               end else begin
                  chk($sformatf("latency op%0d", exp_q[0].op), 32'(cyc - acc_cyc), 32'(exp_q[0].lat));
               end
            end
            if (out_valid && out_ready && !flush && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk($sformatf("rd_data op%0d", e.op), rd_data, e.d);
               hs_cnt++;
            end
         end
         prev_ov = out_valid;
      end
   end

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit expect_res);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: in_ready %b required 1", in_ready);
      end
      if (expect_res) exp_q.push_back('{d: ref_res(o, a, b), lat: ref_lat(o, a, b), op: o});
      in_valid = 1'b1;
      op = o;
      rs1_data = a;
      rs2_data = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = 3'($urandom_range(0, 7));
      rs1_data = $urandom;
      rs2_data = $urandom;
   endtask

   task automatic wait_hs(input int start);
      int n = 0;
      while (hs_cnt == start && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (hs_cnt == start) begin
         checks++;
         errors++;
         $display("FAIL handshake_timeout: handshakes %0d required %0d", hs_cnt, start + 1);
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      int s = hs_cnt;
      issue(o, a, b, 1'b1);
      wait_hs(s);
   endtask

   // Starts an op, aborts it after nine CALC steps by flush or reset, then runs MUL 3*4
   task automatic abort_case(input bit use_reset);
      bit seen = 0;
      issue(3'd5, 32'hDEADBEEF, 32'h00000013, 1'b0);
      repeat (9) begin @(posedge clk); #1; end
      if (use_reset) reset = 1'b1;
      else           flush = 1'b1;
      chk("in_ready_during_abort", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      flush = 1'b0;
      if (use_reset) chk("rd_data_after_reset", rd_data, 32'd0);
      repeat (40) begin
         if (out_valid) seen = 1;
         @(posedge clk); #1;
      end
      chk("aborted_no_valid", {31'b0, seen}, 32'd0);
      run_op(3'd0, 32'd3, 32'd4);
   endtask

   initial begin
      logic [31:0] held;
      int          n, s;
      logic [2:0]  o;
      logic [31:0] a, b;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; rs1_data = '0; rs2_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", {31'b0, in_ready}, 32'd0);
      chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset_rd_data", rd_data, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

      run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op(3'd4, 32'hFFFFFFF9, 32'd2);
      run_op(3'd6, 32'hFFFFFFF9, 32'd2);
      run_op(3'd5, 32'hFFFFFFF9, 32'd2);
      run_op(3'd7, 32'hFFFFFFF9, 32'd2);
      run_op(3'd5, 32'd5, 32'd0);
      run_op(3'd6, 32'd5, 32'd0);
      run_op(3'd4, 32'h80000000, 32'hFFFFFFFF);
      run_op(3'd6, 32'h80000000, 32'hFFFFFFFF);

      // Backpressure: result must hold while out_ready is low
      out_ready = 1'b0;
      s = hs_cnt;
      issue(3'd2, 32'hFFFFFFFF, 32'd2, 1'b1);
      n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk("bp_valid_rise", {31'b0, out_valid}, 32'd1);
      held = rd_data;
      chk("bp_rd_data", held, 32'hFFFFFFFF);
      repeat (5) begin
         @(posedge clk); #1;
         chk("bp_valid_held", {31'b0, out_valid}, 32'd1);
         chk("bp_rd_stable", rd_data, held);
         chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      chk("bp_in_ready_hs_cycle", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      chk("bp_in_ready_after", {31'b0, in_ready}, 32'd1);
      chk("bp_valid_cleared", {31'b0, out_valid}, 32'd0);
      wait_hs(s);

      abort_case(1'b0);
      abort_case(1'b1);

      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: b = $urandom_range(1, 15);
            default: ;
         endcase
         run_op(o, a, b);
      end

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
